// File: rtl/anc_fir_sequencer_if.sv
// Sequencer <-> adaptive FIR bus: operands and start pulse out, result and done pulse back.
`timescale 1ns/1ps
interface anc_fir_sequencer_if;
  logic [15:0] fir_x;
  logic [15:0] fir_a;
  logic [15:0] fir_wadj;
  logic        fir_go;
  logic [15:0] fir_out;
  logic        fir_done;

  modport master (output fir_x, fir_a, fir_wadj, fir_go, input fir_out, fir_done);
  modport slave  (input fir_x, fir_a, fir_wadj, fir_go, output fir_out, fir_done);
endinterface

// File: rtl/anc_fir_sequencer.sv
// Pairs reference/error mic samples, forms the LMS step sat16(mu*e), runs the FIR once
// per pair and forwards its result to the speaker path as a valid-pulsed stream.
`timescale 1ns/1ps
module anc_fir_sequencer #(
  parameter int TIMEOUT_CYCLES = 300,
  parameter int CNT_W          = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [15:0]          ref_in,
  input  logic                 ref_valid,
  input  logic [15:0]          err_in,
  input  logic                 err_valid,
  input  logic [15:0]          a_src,
  input  logic [15:0]          mu,
  input  logic                 adapt_en,
  anc_fir_sequencer_if.master  fir,
  output logic [15:0]          spk_out,
  output logic                 spk_valid,
  output logic                 busy,
  output logic                 overrun,
  output logic                 timeout_err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CALC  = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_OUT   = 3'd4;

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [2:0]         state_reg;
  logic [15:0]        ref_hold_reg, a_hold_reg, err_hold_reg, e_reg;
  logic signed [31:0] prod_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [15:0]        fir_x_reg, fir_a_reg, fir_wadj_reg, spk_out_reg;
  logic               overrun_reg, timeout_reg;

  logic [1:0]         strobe, pend, ovr_hit;
  logic               pair_take;
  logic signed [31:0] mu_ext, e_ext;
  logic signed [16:0] prod_hi;
  logic [15:0]        wadj_sat;

  assign strobe    = {err_valid, ref_valid};
  assign pair_take = (state_reg == S_IDLE) && pend[0] && pend[1];

  // Channel 0 = reference, 1 = error. A strobe coinciding with consumption is a fresh sample.
  for (genvar gi = 0; gi < 2; gi++) begin : g_pend
    logic pend_reg;
    always_ff @(posedge clk) begin
      if (rst)             pend_reg <= 1'b0;
      else if (strobe[gi]) pend_reg <= 1'b1;
      else if (pair_take)  pend_reg <= 1'b0;
    end
    assign pend[gi]    = pend_reg;
    assign ovr_hit[gi] = strobe[gi] && pend_reg && !pair_take;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ref_hold_reg <= '0;
      a_hold_reg   <= '0;
      err_hold_reg <= '0;
      overrun_reg  <= 1'b0;
    end else begin
      if (ref_valid) begin
        ref_hold_reg <= ref_in;
        a_hold_reg   <= a_src;
      end
      if (err_valid)  err_hold_reg <= err_in;
      if (|ovr_hit)   overrun_reg  <= 1'b1;
    end
  end

  assign mu_ext  = {{16{mu[15]}}, mu};
  assign e_ext   = {{16{e_reg[15]}}, e_reg};
  assign prod_hi = prod_reg[31:15];

  // Only -1.0 * -1.0 can leave the q1.15 range; clamp both ends anyway.
  always_comb begin
    wadj_sat = prod_hi[15:0];
    if (prod_hi > 17'sd32767)       wadj_sat = 16'h7FFF;
    else if (prod_hi < -17'sd32768) wadj_sat = 16'h8000;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      e_reg        <= '0;
      prod_reg     <= '0;
      cnt_reg      <= '0;
      fir_x_reg    <= '0;
      fir_a_reg    <= '0;
      fir_wadj_reg <= '0;
      spk_out_reg  <= '0;
      timeout_reg  <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (pair_take) begin
            fir_x_reg <= ref_hold_reg;
            fir_a_reg <= a_hold_reg;
            e_reg     <= err_hold_reg;
            state_reg <= S_CALC;
          end
        end
        S_CALC: begin
          prod_reg  <= mu_ext * e_ext;
          state_reg <= S_ISSUE;
        end
        S_ISSUE: begin
          fir_wadj_reg <= adapt_en ? wadj_sat : 16'h0000;
          cnt_reg      <= '0;
          state_reg    <= S_WAIT;
        end
        S_WAIT: begin
          cnt_reg <= cnt_reg + 1'b1;
          // done on the last allowed cycle still wins over the timeout
          if (fir.fir_done) begin
            spk_out_reg <= fir.fir_out;
            state_reg   <= S_OUT;
          end else if (cnt_reg == TIMEOUT_LAST) begin
            timeout_reg <= 1'b1;
            state_reg   <= S_IDLE;
          end
        end
        S_OUT:   state_reg <= S_IDLE;
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign fir.fir_x    = fir_x_reg;
  assign fir.fir_a    = fir_a_reg;
  assign fir.fir_wadj = fir_wadj_reg;
  assign fir.fir_go   = (state_reg == S_ISSUE);
  assign spk_out      = spk_out_reg;
  assign spk_valid    = (state_reg == S_OUT);
  assign busy         = (state_reg != S_IDLE);
  assign overrun      = overrun_reg;
  assign timeout_err  = timeout_reg;

endmodule

// File: tb/tb_anc_fir_sequencer.sv
// Scoreboarded bench for anc_fir_sequencer with a stub FIR answering a fixed latency after fir_go.
`timescale 1ns/1ps
module tb_anc_fir_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] ref_in = '0, err_in = '0, a_src = '0, mu = '0;
  logic        ref_valid = 1'b0, err_valid = 1'b0, adapt_en = 1'b0;
  logic [15:0] spk_out;
  logic        spk_valid, busy, overrun, timeout_err;

  anc_fir_sequencer_if fif();

  anc_fir_sequencer #(.TIMEOUT_CYCLES(300), .CNT_W(9)) dut (
    .clk        (clk),
    .rst        (rst),
    .ref_in     (ref_in),
    .ref_valid  (ref_valid),
    .err_in     (err_in),
    .err_valid  (err_valid),
    .a_src      (a_src),
    .mu         (mu),
    .adapt_en   (adapt_en),
    .fir        (fif),
    .spk_out    (spk_out),
    .spk_valid  (spk_valid),
    .busy       (busy),
    .overrun    (overrun),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endfunction

  // ---------------- stub FIR ----------------
  int          stub_lat = 263;
  int          stub_cnt = 0;
  logic [15:0] stub_val = '0;
  logic        manual_done = 1'b0;

  initial begin
    fif.fir_out  = '0;
    fif.fir_done = 1'b0;
  end

  always @(negedge clk) begin
    logic fire;
    fire = 1'b0;
    if (fif.fir_go && stub_lat > 0) stub_cnt = stub_lat;
    else if (stub_cnt > 0) begin
      stub_cnt--;
      if (stub_cnt == 0) fire = 1'b1;
    end
    fif.fir_done = fire || manual_done;
    fif.fir_out  = manual_done ? 16'h5555 : (fire ? stub_val : 16'h0000);
  end

  // ---------------- scoreboard + monitor ----------------
  typedef struct packed {
    logic [15:0] x;
    logic [15:0] a;
    logic [15:0] w;
  } go_t;

  go_t         go_q[$];
  logic [15:0] spk_q[$];
  int          go_count = 0, spk_count = 0, go_cyc = 0, spk_cyc = 0;
  logic        wadj_due = 1'b0;
  logic [15:0] wadj_exp = '0;

  always @(negedge clk) begin
    if (wadj_due) begin
      check("fir_wadj", {16'h0, fif.fir_wadj}, {16'h0, wadj_exp});
      wadj_due = 1'b0;
    end
    if (fif.fir_go) begin
      go_count++;
      go_cyc = cyc;
      if (go_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_fir_go: got pulse at cycle %0d, required none", cyc);
      end else begin
        go_t e;
        e = go_q.pop_front();
        $display("go  #%0d cyc=%0d x=0x%04h a=0x%04h", go_count, cyc, fif.fir_x, fif.fir_a);
        check("fir_x", {16'h0, fif.fir_x}, {16'h0, e.x});
        check("fir_a", {16'h0, fif.fir_a}, {16'h0, e.a});
        wadj_exp = e.w;
        wadj_due = 1'b1;
      end
    end
    if (spk_valid) begin
      spk_count++;
      spk_cyc = cyc;
      if (spk_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_spk_valid: got out=0x%04h at cycle %0d, required none", spk_out, cyc);
      end else begin
        logic [15:0] s;
        s = spk_q.pop_front();
        $display("spk #%0d cyc=%0d out=0x%04h", spk_count, cyc, spk_out);
        check("spk_out", {16'h0, spk_out}, {16'h0, s});
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  int strobe_cyc = 0;
  int idle_cyc   = 0;

  task automatic send_pair(input logic [15:0] r, input logic [15:0] a, input logic [15:0] e);
    @(negedge clk);
    ref_in = r; a_src = a; err_in = e;
    ref_valid = 1'b1; err_valid = 1'b1;
    strobe_cyc = cyc;
    @(negedge clk);
    ref_valid = 1'b0; err_valid = 1'b0;
  endtask

  task automatic send_ref(input logic [15:0] r, input logic [15:0] a);
    @(negedge clk);
    ref_in = r; a_src = a; ref_valid = 1'b1;
    @(negedge clk);
    ref_valid = 1'b0;
  endtask

  task automatic send_err(input logic [15:0] e);
    @(negedge clk);
    err_in = e; err_valid = 1'b1;
    @(negedge clk);
    err_valid = 1'b0;
  endtask

  task automatic wait_go(input int n, input int budget);
    int k = 0;
    while (go_count < n && k < budget) begin @(negedge clk); #1; k++; end
    if (go_count < n) begin
      n_checks++;
      $display("FAIL wait_fir_go: got %0d pulses, required %0d", go_count, n);
    end
  endtask

  task automatic wait_spk(input int n, input int budget);
    int k = 0;
    while (spk_count < n && k < budget) begin @(negedge clk); #1; k++; end
    if (spk_count < n) begin
      n_checks++;
      $display("FAIL wait_spk_valid: got %0d pulses, required %0d", spk_count, n);
    end
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    @(negedge clk); #1;
    while (busy && k < budget) begin @(negedge clk); #1; k++; end
    idle_cyc = cyc;
    if (busy) begin
      n_checks++;
      $display("FAIL wait_idle: got busy=1 after %0d cycles, required 0", budget);
    end
  endtask

  task automatic run_one(input logic [15:0] r, input logic [15:0] a, input logic [15:0] e,
                         input logic [15:0] w, input logic [15:0] sv);
    int g0, s0;
    g0 = go_count; s0 = spk_count;
    stub_val = sv;
    go_q.push_back('{x: r, a: a, w: w});
    spk_q.push_back(sv);
    send_pair(r, a, e);
    wait_go(g0 + 1, 20);
    wait_spk(s0 + 1, 400);
    wait_idle(20);
  endtask

  // ---------------- directed sequence ----------------
  logic [15:0] t2_e[3]  = '{16'h8000, 16'h7FFF, 16'h7FFF};
  logic        t2_en[3] = '{1'b1, 1'b1, 1'b0};
  logic [15:0] t2_w[3]  = '{16'h7FFF, 16'h8001, 16'h0000};

  initial begin
    int g0, s0, spk1;

    // reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_busy",     {31'h0, busy},        32'h0);
    check("rst_spk_valid",{31'h0, spk_valid},   32'h0);
    check("rst_fir_go",   {31'h0, fif.fir_go},  32'h0);
    check("rst_overrun",  {31'h0, overrun},     32'h0);
    check("rst_timeout",  {31'h0, timeout_err}, 32'h0);
    check("rst_spk_out",  {16'h0, spk_out},     32'h0);
    check("rst_fir_x",    {16'h0, fif.fir_x},   32'h0);

    // basic pair: latency and step size
    mu = 16'h4000; adapt_en = 1'b1; stub_lat = 263; stub_val = 16'h0ABC;
    g0 = go_count; s0 = spk_count;
    go_q.push_back('{x: 16'h1234, a: 16'h0100, w: 16'h1000});
    spk_q.push_back(16'h0ABC);
    send_pair(16'h1234, 16'h0100, 16'h2000);
    wait_go(g0 + 1, 20);
    check("go_latency", go_cyc - strobe_cyc, 32'd3);
    wait_spk(s0 + 1, 400);
    check("spk_latency", spk_cyc - go_cyc, 32'd264);
    wait_idle(20);
    check("t1_overrun", {31'h0, overrun},     32'h0);
    check("t1_timeout", {31'h0, timeout_err}, 32'h0);
    check("t1_go_count", go_count - g0, 32'd1);

    // saturation and freeze
    mu = 16'h8000;
    for (int i = 0; i < 3; i++) begin
      adapt_en = t2_en[i];
      run_one(16'h0011 + 16'(i), 16'h0022 + 16'(i), t2_e[i], t2_w[i], 16'h0100 + 16'(i));
    end

    // new pair during WAIT is serviced right after OUT
    mu = 16'h4000; adapt_en = 1'b1; stub_val = 16'h1111;
    g0 = go_count; s0 = spk_count;
    go_q.push_back('{x: 16'h0A0A, a: 16'h0B0B, w: 16'h1000});
    spk_q.push_back(16'h1111);
    send_pair(16'h0A0A, 16'h0B0B, 16'h2000);
    wait_go(g0 + 1, 20);
    repeat (20) @(negedge clk);
    go_q.push_back('{x: 16'h0C0C, a: 16'h0D0D, w: 16'hF000});
    spk_q.push_back(16'h2222);
    send_pair(16'h0C0C, 16'h0D0D, 16'hE000);
    wait_spk(s0 + 1, 400);
    spk1 = spk_cyc;
    stub_val = 16'h2222;
    wait_go(g0 + 2, 20);
    check("back_to_back_go", go_cyc - spk1, 32'd3);
    wait_spk(s0 + 2, 400);
    wait_idle(20);
    check("b2b_overrun", {31'h0, overrun}, 32'h0);

    // timeout: FIR never answers
    stub_lat = 0;
    g0 = go_count; s0 = spk_count;
    go_q.push_back('{x: 16'h0F0F, a: 16'h0E0E, w: 16'h1000});
    send_pair(16'h0F0F, 16'h0E0E, 16'h2000);
    wait_go(g0 + 1, 20);
    wait_idle(400);
    check("timeout_err", {31'h0, timeout_err}, 32'h1);
    check("timeout_idle_cycle", idle_cyc - go_cyc, 32'd301);
    check("timeout_no_spk", spk_count - s0, 32'd0);
    stub_lat = 263;
    run_one(16'h0707, 16'h0606, 16'h2000, 16'h1000, 16'h3333);
    check("timeout_sticky", {31'h0, timeout_err}, 32'h1);

    // overrun on the reference channel
    g0 = go_count;
    go_q.push_back('{x: 16'h0002, a: 16'h0AAA, w: 16'h1000});
    spk_q.push_back(16'h4444);
    stub_val = 16'h4444;
    send_ref(16'h0001, 16'h0999);
    send_ref(16'h0002, 16'h0AAA);
    check("overrun_set", {31'h0, overrun}, 32'h1);
    send_err(16'h2000);
    wait_go(g0 + 1, 20);
    wait_spk(spk_count + 1, 400);
    wait_idle(20);
    repeat (5) @(negedge clk);
    check("overrun_one_go", go_count - g0, 32'd1);

    // reset mid-WAIT, then a late done must be ignored
    stub_lat = 0;
    g0 = go_count; s0 = spk_count;
    go_q.push_back('{x: 16'h0123, a: 16'h0456, w: 16'h1000});
    send_pair(16'h0123, 16'h0456, 16'h2000);
    wait_go(g0 + 1, 20);
    repeat (10) @(negedge clk);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    #1;
    check("mid_rst_busy",    {31'h0, busy},        32'h0);
    check("mid_rst_fir_x",   {16'h0, fif.fir_x},   32'h0);
    check("mid_rst_fir_a",   {16'h0, fif.fir_a},   32'h0);
    check("mid_rst_wadj",    {16'h0, fif.fir_wadj},32'h0);
    check("mid_rst_overrun", {31'h0, overrun},     32'h0);
    check("mid_rst_timeout", {31'h0, timeout_err}, 32'h0);
    @(negedge clk); manual_done = 1'b1;
    @(negedge clk); manual_done = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    check("late_done_no_spk", spk_count - s0, 32'd0);
    check("late_done_spk_out", {16'h0, spk_out}, 32'h0);
    check("late_done_busy", {31'h0, busy}, 32'h0);

    check("go_queue_empty",  go_q.size(),  32'd0);
    check("spk_queue_empty", spk_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/anc_fir_sequencer.md
Name: anc_fir_sequencer

Overview:
- Controller stage directly upstream of the adaptive FIR.
- Pairs each reference-mic sample with its error-mic sample and forms the LMS weight step weight_adjust = sat16(mu·e).
- Issues one fir_go per sample pair, waits for the FIR's done, then forwards out_sample to the speaker path as a valid-pulsed stream.
- Provides 1-deep per-channel buffering, overrun/timeout flags, and an adaptation freeze.

Parameters:
- TIMEOUT_CYCLES, 300, maximum cycles from fir_go to fir_done before abort (FIR needs TAPS+7 = 263).
- CNT_W, 9, timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- ref_in  in  16  reference-mic sample, signed q1.15.
- ref_valid  in  1  ref_in strobe.
- err_in  in  16  error-mic sample, signed q1.15.
- err_valid  in  1  err_in strobe.
- a_src  in  16  signed q1.15 accumulator seed for the FIR, sampled with ref_in.
- mu  in  16  signed q1.15 step size, sampled in CALC.
- adapt_en  in  1  0 = freeze: weight_adjust forced to 0.
- fir_x  out  16  to FIR x_in.
- fir_a  out  16  to FIR a_in.
- fir_wadj  out  16  to FIR weight_adjust.
- fir_go  out  1  one-cycle start pulse.
- fir_out  in  16  FIR out_sample.
- fir_done  in  1  FIR done pulse.
- spk_out  out  16  signed speaker sample.
- spk_valid  out  1  one-cycle pulse, spk_out valid.
- busy  out  1  high in every state except IDLE.
- overrun  out  1  sticky; cleared only by rst.
- timeout_err  out  1  sticky; cleared only by rst.

Behaviour:
- Reset, synchronous, dominates everything, also mid-operation:
  - All outputs 0.
  - State IDLE.
  - Pending flags and holding registers cleared.
- Input capture, every cycle and in any state:
  - ref_valid loads ref_hold and a_hold and sets ref_pend.
  - err_valid loads err_hold and sets err_pend.
  - A strobe arriving while that channel's pend is already set overwrites the hold register and sets overrun.
  - A strobe arriving in the same cycle the pend is being consumed counts as a new sample: pend stays set, no overrun.
- FSM states: IDLE, CALC, ISSUE, WAIT, OUT.
  - IDLE: when ref_pend and err_pend are both 1 (pend values as registered), go to CALC.
    - fir_x <= ref_hold, fir_a <= a_hold, e_reg <= err_hold.
    - Clear both pends.
  - CALC: prod <= mu × e_reg, a 32-bit signed product, registered. Go to ISSUE.
  - ISSUE:
    - fir_wadj <= adapt_en ? sat(prod[31:15]) : 0.
    - sat: a 17-bit value outside ±2^15 clamps to 0x7FFF or 0x8000; only 0x8000×0x8000 saturates.
    - fir_go = 1 for exactly this cycle.
    - Clear the timeout counter. Go to WAIT.
  - WAIT:
    - Counter increments each cycle.
    - fir_done goes to OUT, capturing spk_out <= fir_out.
    - If the counter reaches TIMEOUT_CYCLES first: set timeout_err, leave spk_out unchanged, return to IDLE, issue no spk_valid.
    - fir_done in the same cycle the counter hits TIMEOUT_CYCLES counts as success.
  - OUT: spk_valid = 1 for one cycle, then IDLE.
- Output holding:
  - fir_x, fir_a and fir_wadj are held stable from ISSUE until the next IDLE→CALC transition.
  - fir_go is never asserted outside ISSUE.
- Latency: both pends set at cycle N → fir_go at N+2 → spk_valid one cycle after the cycle in which fir_done is sampled. Minimum 4 cycles plus FIR time.
- fir_done seen in any state other than WAIT is ignored.
- Throughput: one pair per FIR run. A new pair may arrive during WAIT and is serviced immediately after OUT with no loss. A second sample on the same channel during that time sets overrun.

Test Plan:
- mu=0x4000, adapt_en=1, err_in=0x2000, ref_in=0x1234, a_src=0x0100, stub FIR returns done 263 cycles after fir_go with out=0x0ABC → fir_wadj=0x1000, fir_x=0x1234, fir_a=0x0100, fir_go high exactly 1 cycle 2 cycles after pairing; spk_out=0x0ABC, spk_valid 1 cycle; overrun=timeout_err=0.
- mu=0x8000, err=0x8000 → fir_wadj=0x7FFF (saturated); mu=0x8000, err=0x7FFF → fir_wadj=0x8001; adapt_en=0 with same inputs → fir_wadj=0x0000.
- ref_valid twice (0x0001 then 0x0002) before any err_valid, then err_valid → overrun=1; FIR receives fir_x=0x0002; exactly one fir_go.
- Stub FIR never asserts done → timeout_err=1 after 300 WAIT cycles, no spk_valid, state returns IDLE; next pair processed normally.
- New ref/err pair arriving during WAIT → serviced immediately after the first spk_valid; second fir_go at OUT+3; overrun stays 0.
- rst asserted for 1 cycle mid-WAIT → all outputs 0 next cycle, busy=0, a late fir_done is ignored, no spk_valid.
